// File: rtl/cdp_int8_sq_window_if.sv
`default_nettype none
// ============================================================================
// Module   : cdp_int8_sq_window_if
// Brief    : Element handshake, register inputs and squared-tap outputs of
//            the CDP int8 channel-window feeder.
// Revision : 1.0
// ============================================================================
interface cdp_int8_sq_window_if #(
  parameter int pINT8_BW = 9,
  parameter int pCH_W    = 13
);
  logic [1:0]            reg2dp_normalz_len;
  logic [pCH_W-1:0]      reg2dp_channel_num;
  logic                  din_vld;
  logic                  din_rdy;
  logic [pINT8_BW-1:0]   din_pd;
  logic [2*pINT8_BW-2:0] sq_pd_int8_0;
  logic [2*pINT8_BW-2:0] sq_pd_int8_1;
  logic [2*pINT8_BW-2:0] sq_pd_int8_2;
  logic [2*pINT8_BW-2:0] sq_pd_int8_3;
  logic [2*pINT8_BW-2:0] sq_pd_int8_4;
  logic [2*pINT8_BW-2:0] sq_pd_int8_5;
  logic [2*pINT8_BW-2:0] sq_pd_int8_6;
  logic [2*pINT8_BW-2:0] sq_pd_int8_7;
  logic [2*pINT8_BW-2:0] sq_pd_int8_8;
  logic                  load_din_d;
  logic                  load_din_2d;
  logic                  len5;
  logic                  len7;
  logic                  len9;

  modport master (
    output reg2dp_normalz_len, reg2dp_channel_num, din_vld, din_pd,
    input  din_rdy,
    input  sq_pd_int8_0, sq_pd_int8_1, sq_pd_int8_2, sq_pd_int8_3, sq_pd_int8_4,
    input  sq_pd_int8_5, sq_pd_int8_6, sq_pd_int8_7, sq_pd_int8_8,
    input  load_din_d, load_din_2d, len5, len7, len9
  );

  modport slave (
    input  reg2dp_normalz_len, reg2dp_channel_num, din_vld, din_pd,
    output din_rdy,
    output sq_pd_int8_0, sq_pd_int8_1, sq_pd_int8_2, sq_pd_int8_3, sq_pd_int8_4,
    output sq_pd_int8_5, sq_pd_int8_6, sq_pd_int8_7, sq_pd_int8_8,
    output load_din_d, load_din_2d, len5, len7, len9
  );
endinterface
`default_nettype wire

// File: rtl/cdp_int8_sq_window.sv
`default_nettype none
// ============================================================================
// Module   : cdp_int8_sq_window
// Brief    : Squares int8-domain elements and keeps a 9-deep zero-padded
//            sliding channel window per pixel for the LRN square-sum block.
// Revision : 1.0
// ============================================================================
module cdp_int8_sq_window #(
  parameter int pINT8_BW = 9,
  parameter int pCH_W    = 13
) (
  input wire logic autosa_core_clk,
  input wire logic autosa_core_rst,
  cdp_int8_sq_window_if.slave if_dp
);
  localparam int c_SQ_W  = 2*pINT8_BW-1;
  localparam int c_CNT_W = pCH_W+1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_CNT_W-1:0]    r_ch_num;
  logic [c_CNT_W-1:0]    w_idx;
  logic [c_SQ_W-1:0]     r_tap [0:8];
  logic signed [c_SQ_W-1:0] w_din_ext;
  logic signed [c_SQ_W-1:0] w_prod;
  logic [c_SQ_W-1:0]     w_new;
  logic                  w_rdy;
  logic                  w_accept;
  logic                  w_shift;
  logic                  w_first;
  logic                  r_ld_d;
  logic                  r_ld_2d;
  logic                  r_len5;
  logic                  r_len7;
  logic                  r_len9;

  assign w_rdy     = (r_state != ST_FLUSH) & ~autosa_core_rst;
  assign w_accept  = if_dp.din_vld & w_rdy;
  assign w_shift   = w_accept | (r_state == ST_FLUSH);
  assign w_first   = w_accept & (r_state == ST_IDLE);
  assign w_idx     = (r_state == ST_IDLE) ? '0 : r_cnt;

  // Sign-extending to the tap width keeps the truncated product exact.
  assign w_din_ext = {{(c_SQ_W-pINT8_BW){if_dp.din_pd[pINT8_BW-1]}}, if_dp.din_pd};
  assign w_prod    = w_din_ext * w_din_ext;
  assign w_new     = (r_state == ST_FLUSH) ? '0 : w_prod;

  always_ff @(posedge autosa_core_clk or posedge autosa_core_rst) begin
    if (autosa_core_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (if_dp.reg2dp_channel_num == '0) ? ST_FLUSH : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_accept && (r_cnt == r_ch_num)) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (r_cnt == r_ch_num + c_CNT_W'(4)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge autosa_core_clk or posedge autosa_core_rst) begin
    if (autosa_core_rst) begin
      r_cnt    <= '0;
      r_ch_num <= '0;
      r_len5   <= 1'b0;
      r_len7   <= 1'b0;
      r_len9   <= 1'b0;
      r_ld_d   <= 1'b0;
      r_ld_2d  <= 1'b0;
    end else begin
      if (w_shift) begin
        r_cnt <= (w_state_nxt == ST_IDLE) ? '0 : w_idx + c_CNT_W'(1);
      end
      if (w_first) begin
        r_ch_num <= {1'b0, if_dp.reg2dp_channel_num};
        r_len5   <= (if_dp.reg2dp_normalz_len == 2'd1);
        r_len7   <= (if_dp.reg2dp_normalz_len == 2'd2);
        r_len9   <= (if_dp.reg2dp_normalz_len == 2'd3);
      end
      r_ld_d  <= w_shift & (w_idx >= c_CNT_W'(4));
      r_ld_2d <= r_ld_d;
    end
  end

  // The first shift of a pixel clears the older taps so nothing leaks across pixels.
  always_ff @(posedge autosa_core_clk or posedge autosa_core_rst) begin
    if (autosa_core_rst) begin
      for (int k = 0; k < 9; k++) begin
        r_tap[k] <= '0;
      end
    end else if (w_shift) begin
      r_tap[8] <= w_new;
      for (int k = 0; k < 8; k++) begin
        r_tap[k] <= w_first ? '0 : r_tap[k+1];
      end
    end
  end

  assign if_dp.din_rdy      = w_rdy;
  assign if_dp.sq_pd_int8_0 = r_tap[0];
  assign if_dp.sq_pd_int8_1 = r_tap[1];
  assign if_dp.sq_pd_int8_2 = r_tap[2];
  assign if_dp.sq_pd_int8_3 = r_tap[3];
  assign if_dp.sq_pd_int8_4 = r_tap[4];
  assign if_dp.sq_pd_int8_5 = r_tap[5];
  assign if_dp.sq_pd_int8_6 = r_tap[6];
  assign if_dp.sq_pd_int8_7 = r_tap[7];
  assign if_dp.sq_pd_int8_8 = r_tap[8];
  assign if_dp.load_din_d   = r_ld_d;
  assign if_dp.load_din_2d  = r_ld_2d;
  assign if_dp.len5         = r_len5;
  assign if_dp.len7         = r_len7;
  assign if_dp.len9         = r_len9;
endmodule
`default_nettype wire

// File: tb/tb_cdp_int8_sq_window.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdp_int8_sq_window
// Brief    : Scoreboard bench for the CDP int8 squared channel-window feeder.
// Revision : 1.0
// ============================================================================
module tb_cdp_int8_sq_window;
  typedef struct packed {
    logic [8:0][16:0] taps;
    logic [1:0]       len;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   strobe_cnt = 0;
  int   first_strobe = -1;
  int   last_strobe = -1;
  logic prev_ld = 1'b0;
  int   stim [0:15];
  sb_t  sb_q [$];
  sb_t  mon_e;
  logic [8:0][16:0] obs_taps;

  cdp_int8_sq_window_if dif ();

  cdp_int8_sq_window dut (
    .autosa_core_clk (clk),
    .autosa_core_rst (rst),
    .if_dp           (dif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs_taps = {dif.sq_pd_int8_8, dif.sq_pd_int8_7, dif.sq_pd_int8_6,
                     dif.sq_pd_int8_5, dif.sq_pd_int8_4, dif.sq_pd_int8_3,
                     dif.sq_pd_int8_2, dif.sq_pd_int8_1, dif.sq_pd_int8_0};

  // Strobe monitor: every centre pops one expected window.
  always @(negedge clk) begin
    if (rst) begin
      prev_ld = 1'b0;
    end else begin
      n_vec++;
      if (dif.load_din_2d !== prev_ld) begin
        n_err++;
        $display("FAIL ld2d_align cyc=%0d got=%b want=%b", cyc, dif.load_din_2d, prev_ld);
      end
      prev_ld = dif.load_din_d;
      if (dif.load_din_d === 1'b1) begin
        strobe_cnt++;
        if (strobe_cnt == 1) first_strobe = cyc;
        last_strobe = cyc;
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_strobe cyc=%0d got=1 want=none", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          if (obs_taps !== mon_e.taps) begin
            n_err++;
            $display("FAIL taps cyc=%0d got=%h want=%h", cyc, obs_taps, mon_e.taps);
          end
          n_vec++;
          if ({dif.len9, dif.len7, dif.len5} !==
              {mon_e.len == 2'd3, mon_e.len == 2'd2, mon_e.len == 2'd1}) begin
            n_err++;
            $display("FAIL len_decode cyc=%0d got=%b want_len=%0d", cyc,
                     {dif.len9, dif.len7, dif.len5}, mon_e.len);
          end
        end
      end
    end
  end

  task automatic send_pixel(input int nch, input int len, input int bub_pct,
                            input int chg_at, input int new_len, input int stop_after,
                            output int first);
    sb_t e;
    int  i = 0;
    int  guard = 0;
    first = -1;
    for (int c = 0; c < nch; c++) begin
      e.len = 2'(len);
      for (int k = 0; k < 9; k++) begin
        int idx = c + k - 4;
        e.taps[k] = (idx >= 0 && idx < nch) ? 17'(stim[idx] * stim[idx]) : 17'd0;
      end
      sb_q.push_back(e);
    end
    dif.reg2dp_normalz_len = 2'(len);
    dif.reg2dp_channel_num = 13'(nch - 1);
    while (i < nch && i != stop_after) begin
      if (i == chg_at) dif.reg2dp_normalz_len = 2'(new_len);
      if (bub_pct > 0 && $urandom_range(0, 99) < bub_pct) begin
        dif.din_vld = 1'b0;
      end else begin
        dif.din_vld = 1'b1;
        dif.din_pd  = 9'(stim[i]);
      end
      @(negedge clk);
      if (dif.din_vld && dif.din_rdy) begin
        if (i == 0) first = cyc;
        i++;
      end
      @(posedge clk);
      #1;
      guard++;
      if (guard > 3000) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout got=%0d beats want=%0d", i, nch);
        break;
      end
    end
    if (stop_after >= 0) dif.din_vld = 1'b0;
  endtask

  task automatic drain(input int n_exp, input int exp_first, input int exp_last, input string nm);
    int g = 0;
    dif.din_vld = 1'b0;
    while (strobe_cnt < n_exp && g < 300) begin
      @(posedge clk);
      g++;
    end
    repeat (8) @(posedge clk);
    #1;
    n_vec++;
    if (strobe_cnt !== n_exp) begin
      n_err++;
      $display("FAIL %s_strobe_count got=%0d want=%0d", nm, strobe_cnt, n_exp);
    end
    if (exp_first >= 0) begin
      n_vec++;
      if (first_strobe !== exp_first || last_strobe !== exp_last) begin
        n_err++;
        $display("FAIL %s_strobe_timing got=%0d..%0d want=%0d..%0d", nm,
                 first_strobe, last_strobe, exp_first, exp_last);
      end
    end
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_missing_strobes got=%0d left want=0", nm, sb_q.size());
    end
    strobe_cnt = 0;
    first_strobe = -1;
    last_strobe = -1;
  endtask

  task automatic check_reset_outputs(input string nm);
    @(negedge clk);
    n_vec++;
    if (dif.din_rdy !== 1'b0 || dif.load_din_d !== 1'b0 || dif.load_din_2d !== 1'b0 ||
        obs_taps !== '0 || {dif.len5, dif.len7, dif.len9} !== 3'b000) begin
      n_err++;
      $display("FAIL %s_in_reset got rdy=%b ld=%b ld2=%b len=%b taps=%h want all 0", nm,
               dif.din_rdy, dif.load_din_d, dif.load_din_2d,
               {dif.len5, dif.len7, dif.len9}, obs_taps);
    end
  endtask

  task automatic test_reset();
    dif.din_vld = 1'b0;
    dif.din_pd = '0;
    dif.reg2dp_normalz_len = '0;
    dif.reg2dp_channel_num = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (dif.din_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_rdy got=%b want=1", dif.din_rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int f;
    stim[0] = -256;
    send_pixel(1, 0, 0, -1, 0, -1, f);
    dif.din_vld = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      n_vec++;
      if (dif.din_rdy !== 1'b0) begin
        n_err++;
        $display("FAIL single_rdy_low t%0d got=%b want=0", t, dif.din_rdy);
      end
    end
    @(negedge clk);
    n_vec++;
    if (dif.din_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL single_rdy_back got=%b want=1", dif.din_rdy);
    end
    drain(1, f + 5, f + 5, "single");
  endtask

  task automatic test_nine();
    int f;
    for (int i = 0; i < 9; i++) stim[i] = i + 1;
    send_pixel(9, 3, 0, -1, 0, -1, f);
    drain(9, f + 5, f + 13, "nine");
  endtask

  task automatic test_back_to_back();
    int f1;
    int f2;
    for (int i = 0; i < 3; i++) stim[i] = i + 2;
    send_pixel(3, 2, 0, -1, 0, -1, f1);
    for (int i = 0; i < 3; i++) stim[i] = i + 5;
    send_pixel(3, 2, 0, -1, 0, -1, f2);
    n_vec++;
    if (f2 !== f1 + 7) begin
      n_err++;
      $display("FAIL b2b_second_accept got=t%0d want=t%0d", f2 - f1, 7);
    end
    drain(6, f1 + 5, f2 + 7, "b2b");
  endtask

  task automatic test_bubbles();
    int f;
    for (int i = 0; i < 9; i++) stim[i] = i + 1;
    send_pixel(9, 3, 40, -1, 0, -1, f);
    drain(9, -1, -1, "bubbles");
    for (int i = 0; i < 9; i++) stim[i] = 8'sd127 - 40 * i;
    send_pixel(9, 1, 50, -1, 0, -1, f);
    drain(9, -1, -1, "bubbles_neg");
  endtask

  task automatic test_len_change_and_reset();
    int f;
    for (int i = 0; i < 9; i++) stim[i] = i + 1;
    send_pixel(9, 3, 0, 4, 1, -1, f);
    drain(9, f + 5, f + 13, "lenchg");
    send_pixel(9, 2, 0, -1, 0, 6, f);
    rst = 1'b1;
    check_reset_outputs("midreset");
    sb_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    strobe_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    n_vec++;
    if (strobe_cnt !== 0) begin
      n_err++;
      $display("FAIL aborted_pixel_strobes got=%0d want=0", strobe_cnt);
    end
    for (int i = 0; i < 5; i++) stim[i] = -100 + 37 * i;
    send_pixel(5, 1, 0, -1, 0, -1, f);
    drain(5, f + 5, f + 9, "post_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_nine();
    test_back_to_back();
    test_bubbles();
    test_len_change_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
